cp0_regfile: RTL and testbench

//  Parametrised CP0 register file: holds BadVAddr, Count, Compare, Status, Cause and EPC.

---
 rtl/coprocessor0_params.sv | 41 ++++
 rtl/cp0_timer.sv | 57 +++++
 rtl/cp0_regfile.sv | 156 +++++++++++++++
 tb/tb_cp0_regfile.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coprocessor0_params.sv
// Shared CP0 definitions: register addresses, writable-bit masks, reset constants
// and the parameter-independent Status/Cause layouts.
package coprocessor0_params;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef struct packed {
        logic [8:0] zero_31_23;
        logic       bev;
        logic [5:0] zero_21_16;
        logic [7:0] im;
        logic [5:0] zero_7_2;
        logic       exl;
        logic       ie;
    } status_t;

    typedef struct packed {
        logic        bd;
        logic        ti;
        logic [13:0] zero_29_16;
        logic [7:0]  ip;
        logic        zero_7;
        logic [4:0]  exc_code;
        logic [1:0]  zero_1_0;
    } cause_t;

    // Only sel=0 is decoded, so a hit needs the low three address bits clear.
    function automatic logic cp0_hit(input logic [7:0] addr, input logic [4:0] rd);
        return addr == {rd, 3'b000};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky timer interrupt.
module cp0_timer
    import coprocessor0_params::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] prescaler_q;

    // A Count write restarts the prescale period so the loaded value holds for a full period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prescaler_q <= '0;
            count       <= '0;
        end else if (count_we) begin
            prescaler_q <= '0;
            count       <= wdata;
        end else if (prescaler_q == PRESC_LAST) begin
            prescaler_q <= '0;
            count       <= count + 32'd1;
        end else begin
            prescaler_q <= prescaler_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            compare <= '0;
        end else if (compare_we) begin
            compare <= wdata;
        end
    end

    // The Compare-write clear beats a same-cycle match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ti <= 1'b0;
        end else if (compare_we) begin
            ti <= 1'b0;
        end else if (count == compare) begin
            ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: mfc0/mtc0 access, exception and eret commit, timer and interrupt flag.
module cp0_regfile
    import coprocessor0_params::*;
#(
    parameter int          HW_INT_NUM = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] VEC_BOOT   = 32'hBFC0_0380,
    parameter logic [31:0] VEC_NORMAL = 32'h8000_0180
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [7:0]            cp0_addr,
    input  logic                  mtc0_we,
    input  logic [31:0]           mtc0_wdata,
    output logic [31:0]           mfc0_rdata,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic                  exc_bd,
    input  logic [31:0]           exc_pc,
    input  logic                  exc_badvaddr_we,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  eret,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic                  int_pending,
    output logic [31:0]           redirect_target,
    output logic [31:0]           epc_out
);

    status_t     status_q;
    cause_t      cause_rd;
    logic        bd_q;
    logic [4:0]  exc_code_q;
    logic [1:0]  sw_ip_q;
    logic [5:0]  hw_ip_q;
    logic [5:0]  hw_ip_next;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        mtc0_take;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic [31:0] exc_vector;

    // An exception or eret in the same cycle swallows the mtc0 completely.
    assign mtc0_take  = mtc0_we & ~exc_valid & ~eret;
    assign wr_count   = mtc0_take & cp0_hit(cp0_addr, CP0_COUNT);
    assign wr_compare = mtc0_take & cp0_hit(cp0_addr, CP0_COMPARE);
    assign wr_status  = mtc0_take & cp0_hit(cp0_addr, CP0_STATUS);
    assign wr_cause   = mtc0_take & cp0_hit(cp0_addr, CP0_CAUSE);
    assign wr_epc     = mtc0_take & cp0_hit(cp0_addr, CP0_EPC);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q <= status_t'(STATUS_RESET);
        end else if (exc_valid) begin
            status_q.exl <= 1'b1;
        end else if (eret) begin
            status_q.exl <= 1'b0;
        end else if (wr_status) begin
            status_q <= status_t'((status_q & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK));
        end
    end

    // A nested exception (EXL already set) keeps the original EPC and BD.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            epc_q      <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            badvaddr_q <= '0;
            sw_ip_q    <= '0;
        end else if (exc_valid) begin
            exc_code_q <= exc_code;
            if (!status_q.exl) begin
                epc_q <= exc_pc - (exc_bd ? 32'd4 : 32'd0);
                bd_q  <= exc_bd;
            end
            if (exc_badvaddr_we) begin
                badvaddr_q <= exc_badvaddr;
            end
        end else if (wr_epc) begin
            epc_q <= mtc0_wdata;
        end else if (wr_cause) begin
            sw_ip_q <= mtc0_wdata[9:8];
        end
    end

    // With all six lines present the top IP bit is shared between hw_int[5] and the timer.
    always_comb begin
        hw_ip_next = '0;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            hw_ip_next[i] = hw_int[i];
        end
        if (HW_INT_NUM == 6) begin
            hw_ip_next[5] = hw_int[HW_INT_NUM-1] | ti;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hw_ip_q <= '0;
        end else begin
            hw_ip_q <= hw_ip_next;
        end
    end

    always_comb begin
        cause_rd          = '0;
        cause_rd.bd       = bd_q;
        cause_rd.ti       = ti;
        cause_rd.ip       = {hw_ip_q, sw_ip_q};
        cause_rd.exc_code = exc_code_q;
        if (HW_INT_NUM < 6) begin
            cause_rd.ip[7] = ti;
        end
    end

    always_comb begin
        mfc0_rdata = '0;
        if (cp0_addr[2:0] == 3'b000) begin
            case (cp0_addr[7:3])
                CP0_BADVADDR: mfc0_rdata = badvaddr_q;
                CP0_COUNT:    mfc0_rdata = count;
                CP0_COMPARE:  mfc0_rdata = compare;
                CP0_STATUS:   mfc0_rdata = status_q;
                CP0_CAUSE:    mfc0_rdata = cause_rd;
                CP0_EPC:      mfc0_rdata = epc_q;
                default:      mfc0_rdata = '0;
            endcase
        end
    end

    assign exc_vector      = status_q.bev ? VEC_BOOT : VEC_NORMAL;
    assign redirect_target = (eret && !exc_valid) ? epc_q : exc_vector;
    assign epc_out         = epc_q;
    assign int_pending     = status_q.ie & ~status_q.exl & (|(cause_rd.ip & status_q.im));

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios plus random traffic against a register-level model.
module tb_cp0_regfile;

    localparam int          HW_INT_NUM = 6;
    localparam int          COUNT_DIV  = 2;
    localparam logic [31:0] VEC_BOOT   = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NORMAL = 32'h8000_0180;

    logic                  clk;
    logic                  resetn;
    logic [7:0]            cp0_addr;
    logic                  mtc0_we;
    logic [31:0]           mtc0_wdata;
    logic [31:0]           mfc0_rdata;
    logic                  exc_valid;
    logic [4:0]            exc_code;
    logic                  exc_bd;
    logic [31:0]           exc_pc;
    logic                  exc_badvaddr_we;
    logic [31:0]           exc_badvaddr;
    logic                  eret;
    logic [HW_INT_NUM-1:0] hw_int;
    logic                  int_pending;
    logic [31:0]           redirect_target;
    logic [31:0]           epc_out;

    int tests_run;
    int tests_failed;

    // Reference state: Count is a load value plus elapsed clocks divided by the prescale.
    logic [31:0] m_badvaddr;
    logic [31:0] m_count_base;
    int          m_ticks;
    logic [31:0] m_compare;
    logic [31:0] m_epc;
    logic [7:0]  m_im;
    logic        m_exl;
    logic        m_ie;
    logic        m_bd;
    logic        m_ti;
    logic        m_ip7;
    logic [4:0]  m_hwip;
    logic [1:0]  m_swip;
    logic [4:0]  m_exccode;

    cp0_regfile #(
        .HW_INT_NUM (HW_INT_NUM),
        .COUNT_DIV  (COUNT_DIV),
        .VEC_BOOT   (VEC_BOOT),
        .VEC_NORMAL (VEC_NORMAL)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .cp0_addr        (cp0_addr),
        .mtc0_we         (mtc0_we),
        .mtc0_wdata      (mtc0_wdata),
        .mfc0_rdata      (mfc0_rdata),
        .exc_valid       (exc_valid),
        .exc_code        (exc_code),
        .exc_bd          (exc_bd),
        .exc_pc          (exc_pc),
        .exc_badvaddr_we (exc_badvaddr_we),
        .exc_badvaddr    (exc_badvaddr),
        .eret            (eret),
        .hw_int          (hw_int),
        .int_pending     (int_pending),
        .redirect_target (redirect_target),
        .epc_out         (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model_count();
        return m_count_base + 32'(m_ticks / COUNT_DIV);
    endfunction

    function automatic logic [31:0] model_status();
        return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] model_cause();
        return {m_bd, m_ti, 14'b0, m_ip7, m_hwip, m_swip, 1'b0, m_exccode, 2'b0};
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        logic [31:0] cause;
        cause = model_cause();
        if (addr[2:0] != 3'b000) return 32'h0;
        case (addr[7:3])
            5'd8:    return m_badvaddr;
            5'd9:    return model_count();
            5'd11:   return m_compare;
            5'd12:   return model_status();
            5'd13:   return cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_pending();
        logic [31:0] cause;
        cause = model_cause();
        return m_ie && !m_exl && ((cause[15:8] & m_im) != 8'h00);
    endfunction

    function automatic logic [31:0] model_redirect();
        if (eret && !exc_valid) return m_epc;
        return VEC_BOOT;
    endfunction

    task automatic model_reset();
        m_badvaddr = 0; m_count_base = 0; m_ticks = 0; m_compare = 0; m_epc = 0;
        m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_ip7 = 0;
        m_hwip = 0; m_swip = 0; m_exccode = 0;
    endtask

    // Next state from the documented rules, using the inputs present at the edge.
    task automatic model_update();
        logic       eq;
        logic       ti_old;
        logic       wr;
        logic [4:0] rd;
        eq     = (model_count() == m_compare);
        ti_old = m_ti;
        wr     = mtc0_we && !exc_valid && !eret && (cp0_addr[2:0] == 3'b000);
        rd     = cp0_addr[7:3];
        if (wr && rd == 5'd9) begin
            m_count_base = mtc0_wdata;
            m_ticks = 0;
        end else begin
            m_ticks++;
        end
        if (wr && rd == 5'd11) begin
            m_compare = mtc0_wdata;
            m_ti = 1'b0;
        end else if (eq) begin
            m_ti = 1'b1;
        end
        m_hwip = hw_int[4:0];
        m_ip7  = hw_int[5] | ti_old;
        if (exc_valid) begin
            m_exccode = exc_code;
            if (!m_exl) begin
                m_epc = exc_pc - (exc_bd ? 32'd4 : 32'd0);
                m_bd  = exc_bd;
            end
            m_exl = 1'b1;
            if (exc_badvaddr_we) m_badvaddr = exc_badvaddr;
        end else if (eret) begin
            m_exl = 1'b0;
        end else if (wr) begin
            case (rd)
                5'd12: begin m_im = mtc0_wdata[15:8]; m_exl = mtc0_wdata[1]; m_ie = mtc0_wdata[0]; end
                5'd13: m_swip = mtc0_wdata[9:8];
                5'd14: m_epc = mtc0_wdata;
                default: ;
            endcase
        end
    endtask

    task automatic clear_inputs();
        cp0_addr = 0; mtc0_we = 0; mtc0_wdata = 0; exc_valid = 0; exc_code = 0;
        exc_bd = 0; exc_pc = 0; exc_badvaddr_we = 0; exc_badvaddr = 0; eret = 0; hw_int = 0;
    endtask

    // One clock: compare every output with the model on the falling edge, then advance both.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput("mfc0_rdata", mfc0_rdata, model_read(cp0_addr));
        checkOutput("int_pending", 32'(int_pending), 32'(model_pending()));
        checkOutput("redirect_target", redirect_target, model_redirect());
        checkOutput("epc_out", epc_out, m_epc);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic write_cp0(input logic [4:0] rd, input logic [31:0] data);
        clear_inputs();
        mtc0_we = 1'b1; cp0_addr = {rd, 3'b000}; mtc0_wdata = data;
        applyStimulus();
        clear_inputs();
    endtask

    task automatic read_check(input string tag, input logic [4:0] rd, input logic [31:0] expected);
        cp0_addr = {rd, 3'b000};
        #1;
        checkOutput(tag, mfc0_rdata, expected);
    endtask

    logic [4:0]  reset_rds  [6] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [31:0] reset_vals [6] = '{32'h0, 32'h0, 32'h0, 32'h0040_0000, 32'h0, 32'h0};
    logic [4:0]  rand_rds   [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd10};

    initial begin
        tests_run = 0;
        tests_failed = 0;
        resetn = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) read_check("reset_reg", reset_rds[i], reset_vals[i]);
        checkOutput("reset_int_pending", 32'(int_pending), 32'h0);
        checkOutput("reset_epc_out", epc_out, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Timer match raises TI and, once enabled, the interrupt.
        write_cp0(5'd11, 32'd5);
        write_cp0(5'd9, 32'd0);
        repeat (10) applyStimulus();
        read_check("count_after_10", 5'd9, 32'd5);
        read_check("cause_ti_not_yet", 5'd13, 32'h0);
        applyStimulus();
        read_check("cause_ti_set", 5'd13, 32'h4000_0000);
        write_cp0(5'd12, 32'h0000_8001);
        checkOutput("timer_int_pending", 32'(int_pending), 32'h1);
        write_cp0(5'd11, 32'h0000_1000);
        cp0_addr = {5'd13, 3'b000};
        #1;
        checkOutput("ti_cleared", 32'(mfc0_rdata[30]), 32'h0);

        // Delay-slot exception, then a nested one that must keep EPC/BD.
        clear_inputs();
        exc_valid = 1; exc_bd = 1; exc_pc = 32'h8000_1004; exc_code = 5'd4;
        exc_badvaddr_we = 1; exc_badvaddr = 32'hDEAD_0000;
        applyStimulus();
        clear_inputs();
        checkOutput("exc_epc", epc_out, 32'h8000_1000);
        read_check("exc_bd", 5'd13, model_cause());
        checkOutput("exc_bd_bit", 32'(mfc0_rdata[31]), 32'h1);
        read_check("exc_status", 5'd12, 32'h0040_8003);
        read_check("exc_badvaddr", 5'd8, 32'hDEAD_0000);
        exc_valid = 1; exc_bd = 0; exc_pc = 32'h1234_5678; exc_code = 5'd8;
        applyStimulus();
        clear_inputs();
        checkOutput("nested_epc", epc_out, 32'h8000_1000);
        read_check("nested_cause", 5'd13, model_cause());
        checkOutput("nested_bd_bit", 32'(mfc0_rdata[31]), 32'h1);
        checkOutput("nested_exccode", 32'(mfc0_rdata[6:2]), 32'd8);

        // Exception, eret and mtc0 Status together: only the exception lands.
        eret = 1;
        applyStimulus();
        clear_inputs();
        exc_valid = 1; exc_pc = 32'h8000_2000; eret = 1;
        mtc0_we = 1; cp0_addr = {5'd12, 3'b000}; mtc0_wdata = 32'h0;
        #1;
        checkOutput("priority_redirect", redirect_target, 32'hBFC0_0380);
        applyStimulus();
        clear_inputs();
        read_check("priority_status", 5'd12, 32'h0040_8003);
        checkOutput("priority_epc", epc_out, 32'h8000_2000);
        eret = 1;
        applyStimulus();
        clear_inputs();

        // Count wrap and prescaler restart on a Count load.
        write_cp0(5'd9, 32'hFFFF_FFFF);
        applyStimulus();
        read_check("count_hold", 5'd9, 32'hFFFF_FFFF);
        applyStimulus();
        read_check("count_wrap", 5'd9, 32'h0);
        applyStimulus();
        write_cp0(5'd9, 32'd100);
        applyStimulus();
        read_check("count_restart_hold", 5'd9, 32'd100);
        applyStimulus();
        read_check("count_restart_inc", 5'd9, 32'd101);

        // Hardware interrupt latency and eret redirect to EPC.
        write_cp0(5'd12, 32'h0000_1001);
        hw_int = 6'b000100;
        #1;
        checkOutput("hw_int_latency", 32'(int_pending), 32'h0);
        applyStimulus();
        checkOutput("hw_int_pending", 32'(int_pending), 32'h1);
        write_cp0(5'd14, 32'hA5A5_0040);
        eret = 1;
        #1;
        checkOutput("eret_redirect", redirect_target, 32'hA5A5_0040);
        applyStimulus();
        clear_inputs();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd;
            rd = rand_rds[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) rd = 5'($urandom);
            exc_valid       = ($urandom_range(0, 9) == 0);
            eret            = ($urandom_range(0, 9) == 0);
            mtc0_we         = ($urandom_range(0, 2) == 0);
            cp0_addr        = {rd, ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000};
            mtc0_wdata      = (rd == 5'd9 || rd == 5'd11) ? 32'($urandom_range(0, 15)) : $urandom;
            exc_code        = 5'($urandom);
            exc_bd          = 1'($urandom);
            exc_pc          = $urandom;
            exc_badvaddr_we = 1'($urandom);
            exc_badvaddr    = $urandom;
            if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
            applyStimulus();
        end
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
